dbg_multicore_cmd_dispatch: RTL and testbench

- Clock-domain-side successor of the per-processor debug slave command decoder, generalised to NUM_CORES Nios II cores.
- Accepts one already-synchronised JTAG debug command (IR code, shift-register word, target core index) and broadcasts the data word as jdo.
- Issues a one-cycle action or no-action strobe to the selected core, then, for monitor reads, waits for that core's monitor_ready with a timeout.
- Returns a single response word (MonDReg plus status) to the host-side controller over a valid/ready handshake.

---
 rtl/dbg_dispatch_pkg.sv | 7 +
 rtl/dbg_multicore_cmd_dispatch_timeout.sv | 16 +
 rtl/dbg_multicore_cmd_dispatch.sv | 117 +++++++++++
 tb/tb_dbg_multicore_cmd_dispatch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dbg_dispatch_pkg.sv
// dbg_dispatch_pkg: instruction codes, action offsets, response codes and FSM states for the debug dispatcher
package dbg_dispatch_pkg;
  localparam int IR_OCIMEM = 0, IR_BREAK = 1, IR_TRACECTRL = 2, IR_NOP = 3;
  localparam int ACT_OCIMEM_A = 0, ACT_OCIMEM_B = 1, ACT_BREAK = 2, ACT_TRACECTRL = 3;
  localparam logic [1:0] ERR_OK = 2'd0, ERR_MON = 2'd1, ERR_TIMEOUT = 2'd2, ERR_BAD_CORE = 2'd3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/dbg_multicore_cmd_dispatch_timeout.sv
// dbg_timeout_counter: counts enabled cycles and flags the last permitted one
module dbg_timeout_counter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (reset || i_clr) ? '0 : i_en ? r_cnt + CNT_W'(1) : r_cnt;
  assign o_expired = i_en && r_cnt == CNT_W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/dbg_multicore_cmd_dispatch.sv
// dbg_multicore_cmd_dispatch: debug command dispatcher for NUM_CORES cores; define DBG_BROADCAST_EN to make all-ones BREAK a broadcast
module dbg_multicore_cmd_dispatch
  import dbg_dispatch_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CORE_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [IR_W-1:0]        cmd_ir,
  input  logic [SR_W-1:0]        cmd_sr,
  input  logic [CORE_W-1:0]      cmd_core,
  output logic [SR_W-1:0]        jdo,
  output logic [NUM_CORES*4-1:0] take_action,
  output logic [NUM_CORES-1:0]   take_no_action,
  input  logic [NUM_CORES-1:0]   monitor_ready,
  input  logic [NUM_CORES-1:0]   monitor_error,
  input  logic [NUM_CORES*32-1:0] mon_dreg,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [1:0]             rsp_err
);
  state_t r_state, w_next;
  logic [SR_W-1:0] r_jdo;
  logic [IR_W-1:0] r_ir;
  logic [CORE_W-1:0] r_core;
  logic r_flag, r_sub_b, r_bcast;
  logic [31:0] r_rsp_data;
  logic [1:0] r_rsp_err;
  logic w_bcast, w_bad, w_nop, w_accept, w_wait_cmd, w_rdy, w_mon_err, w_expired;
  logic [31:0] w_dreg;
  logic [1:0] w_act_off;
`ifdef DBG_BROADCAST_EN
  assign w_bcast = (&cmd_core) && cmd_ir == IR_W'(IR_BREAK);
`else
  assign w_bcast = 1'b0;
`endif
  assign w_bad = 32'(cmd_core) >= NUM_CORES && !w_bcast;
  assign w_nop = cmd_ir == IR_W'(IR_NOP);
  assign w_accept = r_state == IDLE && cmd_valid;
  assign w_wait_cmd = r_ir == IR_W'(IR_OCIMEM) && r_flag && !r_sub_b;
  assign w_act_off = r_ir == IR_W'(IR_OCIMEM) ? (r_sub_b ? 2'(ACT_OCIMEM_B) : 2'(ACT_OCIMEM_A))
                   : r_ir == IR_W'(IR_BREAK) ? 2'(ACT_BREAK) : 2'(ACT_TRACECTRL);
  always_comb begin
    w_rdy = 1'b0;
    w_mon_err = 1'b0;
    w_dreg = '0;
    for (int k = 0; k < NUM_CORES; k++)
      if (r_core == CORE_W'(k)) begin
        w_rdy = monitor_ready[k];
        w_mon_err = monitor_error[k];
        w_dreg = mon_dreg[k*32 +: 32];
      end
  end
  always_comb begin
    take_action = '0;
    take_no_action = '0;
    for (int k = 0; k < NUM_CORES; k++)
      if (r_state == ISSUE && (r_bcast || r_core == CORE_W'(k))) begin
        take_action[k*4 +: 4] = r_flag ? 4'b0001 << w_act_off : 4'b0000;
        take_no_action[k] = !r_flag;
      end
  end
  always_comb
    w_next = r_state == IDLE  ? (cmd_valid ? ((w_bad || w_nop) ? RESP : ISSUE) : IDLE)
           : r_state == ISSUE ? (w_wait_cmd ? WAIT : RESP)
           : r_state == WAIT  ? ((w_rdy || w_expired) ? RESP : WAIT)
           : (rsp_ready ? IDLE : RESP);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_jdo <= '0;
      r_ir <= '0;
      r_core <= '0;
      r_flag <= 1'b0;
      r_sub_b <= 1'b0;
      r_bcast <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err <= ERR_OK;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_jdo <= cmd_sr;
        r_ir <= cmd_ir;
        r_core <= cmd_core;
        r_flag <= cmd_sr[SR_W-1];
        r_sub_b <= cmd_sr[SR_W-2];
        r_bcast <= w_bcast;
        r_rsp_data <= '0;
        r_rsp_err <= w_bad ? ERR_BAD_CORE : ERR_OK;
      end
      if (r_state == WAIT && w_rdy) begin
        r_rsp_data <= w_dreg;
        r_rsp_err <= w_mon_err ? ERR_MON : ERR_OK;
      end else if (r_state == WAIT && w_expired)
        r_rsp_err <= ERR_TIMEOUT;
    end
  end
  dbg_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk),
    .reset(reset),
    .i_clr(r_state != WAIT),
    .i_en(r_state == WAIT),
    .o_expired(w_expired)
  );
  assign cmd_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign jdo = r_jdo;
  assign rsp_data = r_rsp_data;
  assign rsp_err = r_rsp_err;
endmodule

// File: tb/tb_dbg_multicore_cmd_dispatch.sv
// tb_dbg_multicore_cmd_dispatch: directed and randomized commands checked against a transaction-level model
module tb_dbg_multicore_cmd_dispatch;
  localparam int NC = 3, SR_W = 38, IR_W = 2, TO = 16, CW = 2, ND = 6, NCYC = 8000;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic cmd_ready, rsp_valid;
  logic [IR_W-1:0] cmd_ir = '0;
  logic [SR_W-1:0] cmd_sr = '0;
  logic [CW-1:0] cmd_core = '0;
  logic [SR_W-1:0] jdo;
  logic [NC*4-1:0] take_action;
  logic [NC-1:0] take_no_action;
  logic [NC-1:0] monitor_ready = '0, monitor_error = '0;
  logic [NC*32-1:0] mon_dreg = '0;
  logic [31:0] rsp_data;
  logic [1:0] rsp_err;
  dbg_multicore_cmd_dispatch #(.NUM_CORES(NC), .SR_W(SR_W), .IR_W(IR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_sr(cmd_sr), .cmd_core(cmd_core), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .mon_dreg(mon_dreg), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  typedef struct {int ir; int core; bit flag; bit b; int j; int hold; int rst_at; bit beef;} cmd_t;
  cmd_t dir[ND], pend, cur;
  int cyc = 0, n_chk = 0, n_fail = 0, dir_idx = 0, cur_id = -1, acc = 0, rs_start = 0, rdy_cyc = -1;
  bit busy = 1'b0, waiting = 1'b0, post_reset = 1'b0;
  logic [NC*4-1:0] exp_act = '0;
  logic [NC-1:0] exp_noact = '0;
  logic [31:0] exp_data = '0;
  logic [1:0] exp_err = '0;
  logic [SR_W-1:0] exp_jdo = '0;
  logic [NC*4-1:0] obs_act[ND] = '{default: '0};
  logic [NC-1:0] obs_noact[ND] = '{default: '0};
  int obs_off[ND] = '{default: 0};
  logic [31:0] obs_data[ND] = '{default: '0};
  logic [1:0] obs_err[ND] = '{default: '0};
  bit obs_seen[ND] = '{default: 1'b0};
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic accept();
    int off;
    bit bc, bad;
    cur_id++;
    cur = pend;
    acc = cyc - 1;
    exp_jdo = cmd_sr;
    post_reset = 1'b0;
    busy = 1'b1;
    waiting = 1'b0;
    rdy_cyc = -1;
    exp_act = '0;
    exp_noact = '0;
    exp_data = '0;
    exp_err = 2'd0;
`ifdef DBG_BROADCAST_EN
    bc = cmd_core == 2'd3 && cmd_ir == 2'd1;
`else
    bc = 1'b0;
`endif
    bad = int'(cmd_core) >= NC && !bc;
    off = cmd_ir == 2'd0 ? int'(cmd_sr[SR_W-2]) : cmd_ir == 2'd1 ? 2 : 3;
    if (bad || cmd_ir == 2'd3) begin
      rs_start = acc + 1;
      exp_err = bad ? 2'd3 : 2'd0;
    end else begin
      for (int k = 0; k < NC; k++)
        if (bc || k == int'(cmd_core)) begin
          if (cmd_sr[SR_W-1]) exp_act[k*4+off] = 1'b1;
          else exp_noact[k] = 1'b1;
        end
      waiting = cmd_ir == 2'd0 && cmd_sr[SR_W-1] && !cmd_sr[SR_W-2];
      if (!waiting) rs_start = acc + 2;
      else if (cur.j < TO) begin
        rdy_cyc = acc + 2 + cur.j;
        rs_start = rdy_cyc + 1;
      end else begin
        rs_start = acc + 2 + TO;
        exp_err = 2'd2;
      end
    end
  endtask
  initial begin
    dir[0] = '{1, 2, 1'b1, 1'b0, 0, 0, -1, 1'b0};
    dir[1] = '{0, 1, 1'b1, 1'b0, 6, 3, -1, 1'b1};
    dir[2] = '{0, 1, 1'b1, 1'b0, TO + 4, 0, -1, 1'b0};
    dir[3] = '{1, 3, 1'b1, 1'b0, 0, 1, -1, 1'b0};
    dir[4] = '{3, 0, 1'b0, 1'b0, 0, 0, -1, 1'b0};
    dir[5] = '{0, 0, 1'b1, 1'b0, TO + 4, 0, 5, 1'b0};
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        busy = 1'b0;
        exp_jdo = '0;
        post_reset = 1'b1;
      end else if (busy) begin
        if (cyc - 1 >= rs_start && rsp_ready) busy = 1'b0;
      end else if (cmd_valid) accept();
      #1;
      reset = cyc < 3;
      monitor_ready = NC'($urandom);
      monitor_error = NC'($urandom);
      mon_dreg = {$urandom, $urandom, $urandom};
      rsp_ready = 1'($urandom);
      cmd_valid = 1'($urandom);
      cmd_ir = IR_W'($urandom);
      cmd_core = CW'($urandom);
      cmd_sr = SR_W'({$urandom, $urandom});
      if (busy) begin
        if (waiting && cyc >= acc + 2 && cyc < (rdy_cyc >= 0 ? rdy_cyc : acc + 2 + TO))
          monitor_ready[cur.core] = 1'b0;
        if (cyc == rdy_cyc) begin
          monitor_ready[cur.core] = 1'b1;
          if (cur.beef) begin
            mon_dreg[cur.core*32 +: 32] = 32'hDEADBEEF;
            monitor_error[cur.core] = 1'b0;
          end
          exp_data = mon_dreg[cur.core*32 +: 32];
          exp_err = {1'b0, monitor_error[cur.core]};
        end
        if (cyc >= rs_start) rsp_ready = cyc >= rs_start + cur.hold;
        if (cur.rst_at >= 0 && cyc == acc + cur.rst_at) reset = 1'b1;
      end else if (!reset) begin
        if (dir_idx < ND) begin
          pend = dir[dir_idx];
          dir_idx++;
          cmd_valid = 1'b1;
        end else
          pend = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, TO + 3)), int'($urandom_range(0, 3)), -1, 1'b0};
        if (cmd_valid) begin
          cmd_ir = IR_W'(pend.ir);
          cmd_core = CW'(pend.core);
          cmd_sr[SR_W-1] = pend.flag;
          cmd_sr[SR_W-2] = pend.b;
        end
      end
    end
    chk("d0_act", 96'(obs_act[0]), 96'(12'h400));
    chk("d0_off", 96'(obs_off[0]), 96'(2));
    chk("d0_err", 96'(obs_err[0]), 96'(0));
    chk("d1_act", 96'(obs_act[1]), 96'(12'h010));
    chk("d1_data", 96'(obs_data[1]), 96'(32'hDEADBEEF));
    chk("d1_err", 96'(obs_err[1]), 96'(0));
    chk("d1_off", 96'(obs_off[1]), 96'(9));
    chk("d2_err", 96'(obs_err[2]), 96'(2));
    chk("d2_data", 96'(obs_data[2]), 96'(0));
    chk("d2_off", 96'(obs_off[2]), 96'(18));
`ifdef DBG_BROADCAST_EN
    chk("d3_act", 96'(obs_act[3]), 96'(12'h444));
    chk("d3_err", 96'(obs_err[3]), 96'(0));
    chk("d3_off", 96'(obs_off[3]), 96'(2));
`else
    chk("d3_act", 96'(obs_act[3]), 96'(0));
    chk("d3_noact", 96'(obs_noact[3]), 96'(0));
    chk("d3_err", 96'(obs_err[3]), 96'(3));
    chk("d3_off", 96'(obs_off[3]), 96'(1));
`endif
    chk("d4_off", 96'(obs_off[4]), 96'(1));
    chk("d4_err", 96'(obs_err[4]), 96'(0));
    chk("d5_act", 96'(obs_act[5]), 96'(12'h001));
    chk("d5_rsp_seen", 96'(obs_seen[5]), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  always @(negedge clk) begin
    bit strobe_cyc, v;
    if (cyc > 0) begin
      strobe_cyc = busy && cyc == acc + 1;
      v = busy && cyc >= rs_start;
      chk("cmd_ready", 96'(cmd_ready), 96'(!busy));
      chk("take_action", 96'(take_action), 96'(strobe_cyc ? exp_act : '0));
      chk("take_no_action", 96'(take_no_action), 96'(strobe_cyc ? exp_noact : '0));
      chk("jdo", 96'(jdo), 96'(exp_jdo));
      chk("rsp_valid", 96'(rsp_valid), 96'(v));
      if (v) begin
        chk("rsp_data", 96'(rsp_data), 96'(exp_data));
        chk("rsp_err", 96'(rsp_err), 96'(exp_err));
      end
      if (!busy && post_reset) begin
        chk("reset_rsp_data", 96'(rsp_data), 96'(0));
        chk("reset_rsp_err", 96'(rsp_err), 96'(0));
      end
      if (busy && cur_id >= 0 && cur_id < ND) begin
        if (strobe_cyc) begin
          obs_act[cur_id] = take_action;
          obs_noact[cur_id] = take_no_action;
        end
        if (rsp_valid && !obs_seen[cur_id]) begin
          obs_seen[cur_id] = 1'b1;
          obs_off[cur_id] = cyc - acc;
          obs_data[cur_id] = rsp_data;
          obs_err[cur_id] = rsp_err;
        end
      end
    end
  end
endmodule
